// File: rtl/i2c_seq_if.sv
// ============================================================================
//  Module   : i2c_seq_if
//  Purpose  : Command and write-data bus between i2c_seq and an i2c_master.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_seq_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       data_out_last;

  modport master (
    output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
           cmd_stop, cmd_valid, data_out, data_out_valid, data_out_last,
    input  cmd_ready, data_out_ready
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
           cmd_stop, cmd_valid, data_out, data_out_valid, data_out_last,
    output cmd_ready, data_out_ready
  );
endinterface

`default_nettype wire

// File: rtl/i2c_seq.sv
// ============================================================================
//  Module   : i2c_seq
//  Purpose  : Replays a ROM table of I2C operations for DEV_COUNT devices.
//             Define I2C_SEQ_DELAY_EN to enable the DELAY opcode counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_seq #(
  parameter int TABLE_AW    = 8,
  parameter int DEV_COUNT   = 1,
  parameter int DELAY_SHIFT = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  output logic [TABLE_AW-1:0]      table_addr,
  input  wire logic [10:0]         table_data,
  i2c_seq_if.master                bus,
  output logic                     busy,
  input  wire logic                start
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_CMD    = 3'd3,
    S_DATA   = 3'd4,
    S_DELAY  = 3'd5
  } state_t;

  localparam logic [2:0] c_OP_HALT  = 3'd0;
  localparam logic [2:0] c_OP_ADDR  = 3'd1;
  localparam logic [2:0] c_OP_START = 3'd2;
  localparam logic [2:0] c_OP_DATA  = 3'd3;
  localparam logic [2:0] c_OP_LAST  = 3'd4;
  localparam logic [2:0] c_OP_DELAY = 3'd5;
  localparam logic [2:0] c_OP_STOP  = 3'd6;

  localparam logic [TABLE_AW-1:0] c_PTR_MAX  = {TABLE_AW{1'b1}};
  localparam logic [6:0]          c_DEV_LAST = 7'(DEV_COUNT - 1);

  state_t              r_state, w_state;
  logic [TABLE_AW-1:0] r_ptr, w_ptr;
  logic                r_end, w_end;
  logic [6:0]          r_dev, w_dev;
  logic [6:0]          r_base, w_base;
  logic                r_busy, w_busy;
  logic [6:0]          r_cmd_addr, w_cmd_addr;
  logic                r_cmd_valid, w_cmd_valid;
  logic                r_cmd_start, w_cmd_start;
  logic                r_cmd_wm, w_cmd_wm;
  logic                r_cmd_stop, w_cmd_stop;
  logic [7:0]          r_dout, w_dout;
  logic                r_dout_valid, w_dout_valid;
  logic                r_dout_last, w_dout_last;

  logic [2:0]          w_op;
  logic [7:0]          w_arg;
  logic [TABLE_AW-1:0] w_ptr_adv;
  logic                w_end_adv;

`ifdef I2C_SEQ_DELAY_EN
  localparam int c_CNT_W = 9 + DELAY_SHIFT;
  logic [c_CNT_W-1:0] r_cnt, w_cnt;
`endif

  // Past the last word the pointer parks and the next decode is forced to HALT.
  assign w_op      = r_end ? c_OP_HALT : table_data[10:8];
  assign w_arg     = table_data[7:0];
  assign w_end_adv = (r_ptr == c_PTR_MAX);
  assign w_ptr_adv = w_end_adv ? r_ptr : r_ptr + 1'b1;

  always_comb begin
    w_state      = r_state;
    w_ptr        = r_ptr;
    w_end        = r_end;
    w_dev        = r_dev;
    w_base       = r_base;
    w_busy       = r_busy;
    w_cmd_addr   = r_cmd_addr;
    w_cmd_valid  = r_cmd_valid;
    w_cmd_start  = r_cmd_start;
    w_cmd_wm     = r_cmd_wm;
    w_cmd_stop   = r_cmd_stop;
    w_dout       = r_dout;
    w_dout_valid = r_dout_valid;
    w_dout_last  = r_dout_last;
`ifdef I2C_SEQ_DELAY_EN
    w_cnt        = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_FETCH;
          w_ptr   = '0;
          w_end   = 1'b0;
          w_dev   = '0;
          w_busy  = 1'b1;
        end
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        w_state = S_FETCH;
        w_ptr   = w_ptr_adv;
        w_end   = w_end_adv;
        case (w_op)
          c_OP_HALT: begin
            if (r_dev < c_DEV_LAST) begin
              w_dev = r_dev + 7'd1;
              w_ptr = '0;
              w_end = 1'b0;
            end else begin
              w_state = S_IDLE;
              w_ptr   = r_ptr;
              w_end   = r_end;
              w_busy  = 1'b0;
            end
          end
          c_OP_ADDR: w_base = w_arg[6:0];
          c_OP_START, c_OP_STOP: begin
            w_state     = S_CMD;
            w_ptr       = r_ptr;
            w_end       = r_end;
            w_cmd_valid = 1'b1;
            w_cmd_addr  = r_base + r_dev;
            w_cmd_start = (w_op == c_OP_START);
            w_cmd_wm    = (w_op == c_OP_START);
            w_cmd_stop  = (w_op == c_OP_STOP);
          end
          c_OP_DATA, c_OP_LAST: begin
            w_state      = S_DATA;
            w_ptr        = r_ptr;
            w_end        = r_end;
            w_dout       = w_arg;
            w_dout_last  = (w_op == c_OP_LAST);
            w_dout_valid = 1'b1;
          end
`ifdef I2C_SEQ_DELAY_EN
          c_OP_DELAY: begin
            w_state = S_DELAY;
            w_ptr   = r_ptr;
            w_end   = r_end;
            w_cnt   = c_CNT_W'({1'b0, w_arg} + 9'd1) << DELAY_SHIFT;
          end
`endif
          default: ;
        endcase
      end
      S_CMD: begin
        if (bus.cmd_ready) begin
          w_state     = S_FETCH;
          w_ptr       = w_ptr_adv;
          w_end       = w_end_adv;
          w_cmd_valid = 1'b0;
          w_cmd_start = 1'b0;
          w_cmd_wm    = 1'b0;
          w_cmd_stop  = 1'b0;
          w_cmd_addr  = '0;
        end
      end
      S_DATA: begin
        if (bus.data_out_ready) begin
          w_state      = S_FETCH;
          w_ptr        = w_ptr_adv;
          w_end        = w_end_adv;
          w_dout_valid = 1'b0;
          w_dout_last  = 1'b0;
        end
      end
`ifdef I2C_SEQ_DELAY_EN
      S_DELAY: begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt == c_CNT_W'(1)) begin
          w_state = S_FETCH;
          w_ptr   = w_ptr_adv;
          w_end   = w_end_adv;
        end
      end
`endif
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_end        <= 1'b0;
      r_dev        <= '0;
      r_base       <= '0;
      r_busy       <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_start  <= 1'b0;
      r_cmd_wm     <= 1'b0;
      r_cmd_stop   <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
`ifdef I2C_SEQ_DELAY_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_ptr        <= w_ptr;
      r_end        <= w_end;
      r_dev        <= w_dev;
      r_base       <= w_base;
      r_busy       <= w_busy;
      r_cmd_addr   <= w_cmd_addr;
      r_cmd_valid  <= w_cmd_valid;
      r_cmd_start  <= w_cmd_start;
      r_cmd_wm     <= w_cmd_wm;
      r_cmd_stop   <= w_cmd_stop;
      r_dout       <= w_dout;
      r_dout_valid <= w_dout_valid;
      r_dout_last  <= w_dout_last;
`ifdef I2C_SEQ_DELAY_EN
      r_cnt        <= w_cnt;
`endif
    end
  end

  assign table_addr             = r_ptr;
  assign busy                   = r_busy;
  assign bus.cmd_address        = r_cmd_addr;
  assign bus.cmd_valid          = r_cmd_valid;
  assign bus.cmd_start          = r_cmd_start;
  assign bus.cmd_write_multiple = r_cmd_wm;
  assign bus.cmd_stop           = r_cmd_stop;
  assign bus.cmd_read           = 1'b0;
  assign bus.cmd_write          = 1'b0;
  assign bus.data_out           = r_dout;
  assign bus.data_out_valid     = r_dout_valid;
  assign bus.data_out_last      = r_dout_last;

endmodule

`default_nettype wire

// File: tb/tb_i2c_seq.sv
// ============================================================================
//  Module   : tb_i2c_seq
//  Purpose  : Scoreboard bench for i2c_seq (TABLE_AW=3, DEV_COUNT=3, DELAY_SHIFT=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_seq;
  localparam int AW = 3;
  localparam int DC = 3;
  localparam int DS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] table_addr;
  logic [10:0]   table_data;
  logic          busy;
  logic [10:0]   rom [8];

  i2c_seq_if bus ();

  i2c_seq #(.TABLE_AW(AW), .DEV_COUNT(DC), .DELAY_SHIFT(DS)) dut (
    .clk        (clk),
    .rst        (rst),
    .table_addr (table_addr),
    .table_data (table_data),
    .bus        (bus),
    .busy       (busy),
    .start      (start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) table_data <= rom[table_addr];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [6:0]  m_base = 7'd0;
  bit          stall_en = 1'b0;
  bit          data_hold = 1'b0;
  bit          want_first = 1'b0;
  longint      t_first = 0;
  longint      t0 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] txn(input logic kind, input logic [6:0] addr,
                                      input logic [4:0] flags, input logic [7:0] d,
                                      input logic last);
    return {10'd0, kind, addr, flags, d, last};
  endfunction

  // Reference walk of the table: flags = {start, write_multiple, stop, read, write}.
  task automatic model_run();
    for (int d = 0; d < DC; d++) begin
      int p = 0;
      bit halted = 1'b0;
      while (p < 8 && !halted) begin
        logic [2:0] op;
        logic [7:0] arg;
        logic [6:0] a;
        op  = rom[p][10:8];
        arg = rom[p][7:0];
        a   = m_base + 7'(d);
        case (op)
          3'd0: halted = 1'b1;
          3'd1: m_base = arg[6:0];
          3'd2: exp_q.push_back(txn(1'b0, a, 5'b11000, 8'd0, 1'b0));
          3'd3: exp_q.push_back(txn(1'b1, 7'd0, 5'd0, arg, 1'b0));
          3'd4: exp_q.push_back(txn(1'b1, 7'd0, 5'd0, arg, 1'b1));
          3'd6: exp_q.push_back(txn(1'b0, a, 5'b00100, 8'd0, 1'b0));
          default: ;
        endcase
        p++;
      end
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check_eq({tag, "_underflow"}, exp_q.size(), 1);
    else check_eq(tag, got, exp_q.pop_front());
  endtask

  int          stall_left = 0;
  bit          prev_cv = 1'b0;
  bit          prev_cacc = 1'b0;
  bit          prev_dacc = 1'b0;
  logic [31:0] snap;
  logic [31:0] cur_c;
  logic [31:0] cur_d;

  always @(negedge clk) begin
    if (!rst) begin
      cur_c = txn(1'b0, bus.cmd_address, {bus.cmd_start, bus.cmd_write_multiple,
                  bus.cmd_stop, bus.cmd_read, bus.cmd_write}, 8'd0, 1'b0);
      cur_d = txn(1'b1, 7'd0, 5'd0, bus.data_out, bus.data_out_last);
      if (prev_cacc) check_eq("cmd_drop", bus.cmd_valid, 0);
      if (prev_dacc) check_eq("data_drop", bus.data_out_valid, 0);
      if (bus.cmd_valid) check_eq("excl", bus.data_out_valid, 0);
      if (stall_en && bus.cmd_valid && !prev_cv) begin
        stall_left = 10;
        snap = cur_c;
      end
      if (stall_left > 0) begin
        if (stall_left < 10) begin
          check_eq("stall_valid", bus.cmd_valid, 1);
          check_eq("stall_hold", cur_c, snap);
        end
        bus.cmd_ready = 1'b0;
        stall_left--;
      end else begin
        bus.cmd_ready = 1'b1;
      end
      bus.data_out_ready = !data_hold;
      if (want_first && bus.cmd_valid) begin
        t_first = longint'($time);
        want_first = 1'b0;
      end
      prev_cacc = bus.cmd_valid && bus.cmd_ready;
      prev_dacc = bus.data_out_valid && bus.data_out_ready;
      if (prev_cacc) sb_pop("cmd", cur_c);
      if (prev_dacc) sb_pop("data", cur_d);
      prev_cv = bus.cmd_valid;
    end
  end

  // exp_lat: negedges from the start pulse to the first visible cmd_valid.
  task automatic run_seq(input string tag, input int exp_lat);
    int n;
    model_run();
    @(negedge clk);
    check_eq({tag, "_idle"}, busy, 0);
    want_first = 1'b1;
    start = 1'b1;
    t0 = longint'($time);
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, busy, 0);
    check_eq({tag, "_sb_left"}, exp_q.size(), 0);
    check_eq({tag, "_lat"}, 32'((t_first - t0) / 10), exp_lat);
    exp_q.delete();
  endtask

  task automatic load_a();
    for (int i = 0; i < 8; i++) rom[i] = 11'h000;
    rom[0] = {3'd1, 8'h50};
    rom[1] = {3'd2, 8'h00};
    rom[2] = {3'd3, 8'h12};
    rom[3] = {3'd4, 8'h34};
    rom[4] = {3'd6, 8'h00};
    rom[5] = {3'd0, 8'h00};
  endtask

  initial begin
    int n;
    bus.cmd_ready = 1'b1;
    bus.data_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) rom[i] = 11'h000;
    repeat (3) @(negedge clk);
    check_eq("rst_addr", table_addr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd", {bus.cmd_valid, bus.cmd_address, bus.cmd_start, bus.cmd_read,
                         bus.cmd_write, bus.cmd_write_multiple, bus.cmd_stop}, 0);
    check_eq("rst_data", {bus.data_out_valid, bus.data_out, bus.data_out_last}, 0);
    rst = 1'b0;

    load_a();
    run_seq("basic", 5);

    stall_en = 1'b1;
    run_seq("stall", 5);
    stall_en = 1'b0;

    for (int i = 0; i < 8; i++) rom[i] = 11'h000;
    rom[0] = {3'd1, 8'h20};
    rom[1] = {3'd5, 8'h02};
    rom[2] = {3'd2, 8'h00};
    rom[3] = {3'd6, 8'h00};
`ifdef I2C_SEQ_DELAY_EN
    run_seq("delay", 55);
`else
    run_seq("delay", 7);
`endif

    rom[0] = {3'd1, 8'h7F};
    rom[1] = {3'd2, 8'h00};
    rom[2] = {3'd3, 8'h01};
    rom[3] = {3'd3, 8'h02};
    rom[4] = {3'd3, 8'h03};
    rom[5] = {3'd4, 8'h04};
    rom[6] = {3'd6, 8'h00};
    rom[7] = {3'd7, 8'h00};
    run_seq("nohalt", 5);

    load_a();
    model_run();
    data_hold = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.data_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach", bus.data_out_valid, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async", {table_addr, busy, bus.cmd_valid, bus.cmd_address, bus.cmd_start,
                           bus.cmd_write_multiple, bus.cmd_stop, bus.data_out_valid,
                           bus.data_out, bus.data_out_last}, 0);
    @(negedge clk);
    rst = 1'b0;
    data_hold = 1'b0;
    exp_q.delete();
    m_base = 7'd0;
    run_seq("replay", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time=%0t limit=400000", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/i2c_seq.md
I2C_SEQ -- requirements
Module: i2c_seq

Interface
REQ-001 Parameter TABLE_AW, default 8: table address width; the table holds 2^TABLE_AW words.
REQ-002 Parameter DEV_COUNT, default 1: number of devices the table is replayed for (1..128).
REQ-003 Parameter DELAY_SHIFT, default 8: left shift applied to the DELAY argument.
REQ-004 clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 table_addr  out  TABLE_AW  table word address; the word appears on table_data one clk later (synchronous ROM).
REQ-007 table_data  in  11  table word: op = [10:8], arg = [7:0].
REQ-008 cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop  out  7,1,1,1,1,1  command fields to the i2c_master.
REQ-009 cmd_valid / cmd_ready  out / in  1 / 1  command handshake.
REQ-010 data_out, data_out_valid, data_out_ready, data_out_last  out,out,in,out  8,1,1,1  write data stream.
REQ-011 busy  out  1  sequence in progress.
REQ-012 start  in  1  single-cycle pulse that launches the sequence.

Function
REQ-013 States: IDLE, FETCH, DECODE, CMD, DATA, DELAY.
REQ-014 IDLE: on start=1, go to FETCH with ptr=0 and dev=0; busy=1 from the next cycle; start is ignored in every other state.
REQ-015 FETCH: drive table_addr=ptr for one cycle, then go to DECODE; table_data is sampled in DECODE.
REQ-016 op 0 HALT: if dev<DEV_COUNT-1, set dev=dev+1 and ptr=0, then FETCH; otherwise go to IDLE with busy=0.
REQ-017 op 1 ADDR: latch base=arg[6:0], set ptr+1, then FETCH; no bus activity.
REQ-018 op 2 START: drive cmd_start=1, cmd_write_multiple=1, all other command flags 0, then go to CMD.
REQ-019 op 6 STOP: drive cmd_stop=1, all other command flags 0, then go to CMD.
REQ-020 cmd_address = (base + dev) mod 128 whenever cmd_valid=1.
REQ-021 CMD: hold cmd_valid=1 with stable fields until the cycle in which cmd_valid and cmd_ready are both 1; the next cycle cmd_valid=0, ptr+1, FETCH.
REQ-022 op 3 DATA / op 4 DATA_LAST: data_out=arg, data_out_last=0 / 1, then go to DATA.
REQ-023 DATA: hold data_out_valid=1 with stable data until data_out_valid and data_out_ready are both 1; then ptr+1, FETCH.
REQ-024 op 5 DELAY: load the counter with (arg+1)<<DELAY_SHIFT, decrement it once per clk in DELAY, then ptr+1, FETCH when it reaches 0.
REQ-025 op 7 (reserved) is a NOP: ptr+1, FETCH.
REQ-026 cmd_read and cmd_write are constant 0.
REQ-027 Table end: a non-HALT word at ptr = 2^TABLE_AW-1 executes; the following fetch is treated as HALT without reading the table; ptr never wraps.
REQ-028 cmd_valid and data_out_valid are never asserted in the same cycle.
REQ-029 Outputs are registered; table_data does not reach any output combinationally.

Reset
REQ-030 rst=1 forces IDLE and clears table_addr, cmd_*, data_out*, busy, ptr, dev, base and the delay counter to 0 immediately (asynchronously).
REQ-031 Reset mid-transaction abandons the sequence; recovering the i2c_master is the system's responsibility.

Configuration
REQ-032 Macro I2C_SEQ_DELAY_EN defined: op 5 behaves per REQ-024.
REQ-033 Macro I2C_SEQ_DELAY_EN undefined: the delay counter is omitted and op 5 executes as a NOP (one FETCH/DECODE pass).

Verification
REQ-034 Table {ADDR 0x50, START, DATA 0x12, DATA_LAST 0x34, STOP, HALT}, ready held 1 -> command at address 0x50 with start and write_multiple; bytes 0x12 then 0x34 with last=1; stop command; busy falls.
REQ-035 Same table, DEV_COUNT=3 -> three passes at addresses 0x50, 0x51, 0x52, in that order.
REQ-036 cmd_ready held 0 for 10 cycles after cmd_valid rises -> cmd_valid and all command fields stay stable; the command completes the cycle ready rises.
REQ-037 DELAY arg=2, DELAY_SHIFT=4, I2C_SEQ_DELAY_EN defined -> exactly 48 cycles in DELAY; undefined -> no DELAY state.
REQ-038 Table with no HALT, TABLE_AW=3 -> eight words execute, then busy=0.
REQ-039 rst pulsed while in DATA -> all outputs 0 the same cycle; a later start replays the table from ptr=0.
